// File: rtl/seq_det_pkg.sv
// Shared widths, reset defaults, config payload and length-mask helper for the programmable sequence detector.
package seq_det_pkg;

   localparam int unsigned SD_PAT_MAX = 8;
   localparam int unsigned LEN_W      = $clog2(SD_PAT_MAX + 1);
   localparam int unsigned SD_CNT_W   = 16;

   localparam logic [SD_PAT_MAX-1:0] SD_DEF_PATTERN = 8'b0000_1101;
   localparam int unsigned           SD_DEF_LEN     = 4;
   localparam bit                    SD_DEF_OVERLAP = 1'b1;

   typedef struct packed {
      logic [SD_PAT_MAX-1:0] pattern;
      logic [LEN_W-1:0]      len;
      logic                  overlap;
   } cfg_t;

   // Low 'len' bits set; selects the active window of the candidate history.
   function automatic logic [SD_PAT_MAX-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [SD_PAT_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < int'(SD_PAT_MAX); i++) begin
         m[i] = (i < int'(len));
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating count of usable history bits.
module seq_det_hist #(
   parameter int unsigned PAT_MAX = 8,
   parameter int unsigned FILL_W  = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               shift_en,
   input  logic               din,
   input  logic               clr_fill,
   input  logic               flush,
   output logic [PAT_MAX-1:0] hist,
   output logic [FILL_W-1:0]  fill
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist <= '0;
         fill <= '0;
      end else if (flush) begin
         hist <= '0;
         fill <= '0;
      end else if (shift_en) begin
         hist <= {hist[PAT_MAX-2:0], din};
         // A non-overlapping match retires every bit seen so far.
         if (clr_fill) begin
            fill <= '0;
         end else if (fill != FILL_W'(PAT_MAX)) begin
            fill <= fill + FILL_W'(1);
         end
      end
   end

endmodule

// File: rtl/mealy_seq_detector_prog.sv
// Run-time programmable Mealy pattern detector; optional saturating match counter under SEQ_DET_MATCH_CNT_EN.
// PAT_MAX must equal seq_det_pkg::SD_PAT_MAX since the config payload type is sized there.
module mealy_seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int unsigned        PAT_MAX     = SD_PAT_MAX,
   parameter logic [PAT_MAX-1:0] DEF_PATTERN = SD_DEF_PATTERN,
   parameter int unsigned        DEF_LEN     = SD_DEF_LEN,
   parameter bit                 DEF_OVERLAP = SD_DEF_OVERLAP,
   parameter int unsigned        CNT_W       = SD_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         din,
   input  logic                         din_valid,
   input  logic                         cfg_load,
   input  logic [PAT_MAX-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         cnt_clr,
   output logic                         dout,
   output logic                         cfg_err,
   output logic [CNT_W-1:0]             match_cnt
);

   cfg_t               cfg_q;
   logic [PAT_MAX-1:0] hist;
   logic [LEN_W-1:0]   fill;
   logic [PAT_MAX-1:0] cand;
   logic               cfg_ok;
   logic               load_acc;
   logic               match;
   logic               unused_hist_msb;

   assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
   assign load_acc = cfg_load & cfg_ok;

   // Compare the would-be history after this beat against the active window of the pattern.
   assign cand  = {hist[PAT_MAX-2:0], din};
   assign match = (({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, cfg_q.len}) &&
                  (((cand ^ cfg_q.pattern) & len_mask(cfg_q.len)) == '0);
   assign dout  = din_valid & match & ~load_acc;

   assign unused_hist_msb = hist[PAT_MAX-1];

   seq_det_hist #(
      .PAT_MAX (PAT_MAX),
      .FILL_W  (LEN_W)
   ) u_hist (
      .clk      (clk),
      .reset_n  (reset_n),
      .shift_en (din_valid & ~load_acc),
      .din      (din),
      .clr_fill (match & ~cfg_q.overlap),
      .flush    (load_acc),
      .hist     (hist),
      .fill     (fill)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_q.pattern <= DEF_PATTERN;
         cfg_q.len     <= LEN_W'(DEF_LEN);
         cfg_q.overlap <= DEF_OVERLAP;
         cfg_err       <= 1'b0;
      end else begin
         cfg_err <= cfg_load & ~cfg_ok;
         if (load_acc) begin
            cfg_q.pattern <= cfg_pattern;
            cfg_q.len     <= cfg_len;
            cfg_q.overlap <= cfg_overlap;
         end
      end
   end

`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Clear has priority over a coincident match; count sticks at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (dout && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign match_cnt = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector_prog.sv
// Randomised and directed bench for mealy_seq_detector_prog against a queue-based reference model.
module tb_mealy_seq_detector_prog;

   localparam int unsigned PAT_MAX = 8;
   localparam int unsigned LW      = 4;
   localparam int unsigned CNT_W   = 2;
   localparam int          CNT_MAX = 3;
`ifdef SEQ_DET_MATCH_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset_n;
   logic               din;
   logic               din_valid;
   logic               cfg_load;
   logic [PAT_MAX-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic               cfg_overlap;
   logic               cnt_clr;
   logic               dout;
   logic               cfg_err;
   logic [CNT_W-1:0]   match_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bits still available for matching, oldest first.
   bit       q[$];
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   int       m_cnt;
   bit       m_err;

   mealy_seq_detector_prog #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .dout        (dout),
      .cfg_err     (cfg_err),
      .match_cnt   (match_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit m_match(input bit d);
      int n;
      bit b;
      n = q.size();
      if (n + 1 < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         b = (k == m_len - 1) ? d : q[n - (m_len - 1) + k];
         if (b != m_pat[m_len - 1 - k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void m_beat(input bit d, input bit hit);
      if (hit && !m_ovl) begin
         q.delete();
      end else begin
         q.push_back(d);
         if (q.size() > PAT_MAX) void'(q.pop_front());
      end
   endfunction

   function automatic void m_count(input bit hit, input bit clr);
      if (!CNT_EN || clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
   endfunction

   function automatic void m_reset();
      q.delete();
      m_pat = 8'b0000_1101;
      m_len = 4;
      m_ovl = 1'b1;
      m_cnt = 0;
      m_err = 1'b0;
   endfunction

   task automatic set_in(input bit v, input bit d, input bit clr);
      @(negedge clk);
      din_valid = v;
      din       = d;
      cnt_clr   = clr;
      cfg_load  = 1'b0;
      #1;
   endtask

   task automatic clock_beat(input bit v, input bit d, input bit clr);
      bit hit;
      hit = v && m_match(d);
      @(posedge clk);
      if (v) m_beat(d, hit);
      m_count(hit, clr);
      m_err = 1'b0;
      #1;
   endtask

   // Drives one load cycle; leaves cfg_load low at the following negedge.
   task automatic do_load(input bit [7:0] pat, input int len, input bit ovl,
                          input bit v, input bit d, output bit dout_seen);
      bit ok;
      ok = (len >= 1) && (len <= PAT_MAX);
      @(negedge clk);
      cfg_load    = 1'b1;
      cfg_pattern = pat;
      cfg_len     = LW'(len);
      cfg_overlap = ovl;
      din_valid   = v;
      din         = d;
      cnt_clr     = 1'b0;
      #1;
      dout_seen = dout;
      @(posedge clk);
      if (ok) begin
         m_pat = pat;
         m_len = len;
         m_ovl = ovl;
         q.delete();
      end else if (v) begin
         m_beat(d, m_match(d));
      end
      m_err = !ok;
      @(negedge clk);
      cfg_load  = 1'b0;
      din_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      din = 1'b1; din_valid = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      m_reset();
      #12;
      n_checks++;
      if (dout !== 1'b0) $display("FAIL reset_dout got=%b want=0", dout); else n_pass++;
      n_checks++;
      if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got=%b want=0", cfg_err); else n_pass++;
      n_checks++;
      if (match_cnt !== '0) $display("FAIL reset_cnt got=%0d want=0", match_cnt); else n_pass++;
      @(negedge clk);
      din_valid = 1'b0;
      reset_n   = 1'b1;
   endtask

   task automatic run_stream(input string tag, input bit [15:0] bits, input int n);
      bit exp;
      for (int i = n - 1; i >= 0; i--) begin
         set_in(1'b1, bits[i], 1'b0);
         exp = m_match(bits[i]);
         n_checks++;
         if (dout !== exp) $display("FAIL %s_dout beat=%0d got=%b want=%b", tag, n - i, dout, exp);
         else n_pass++;
         clock_beat(1'b1, bits[i], 1'b0);
      end
      n_checks++;
      if (match_cnt !== CNT_W'(m_cnt)) $display("FAIL %s_cnt got=%0d want=%0d", tag, match_cnt, m_cnt);
      else n_pass++;
   endtask

   task automatic test_overlap();
      run_stream("ovl", 16'b110_1101, 7);
      n_checks++;
      if (int'(match_cnt) !== (CNT_EN ? 2 : 0))
         $display("FAIL ovl_total got=%0d want=%0d", match_cnt, CNT_EN ? 2 : 0);
      else n_pass++;
   endtask

   task automatic test_non_overlap();
      bit ds;
      do_load(8'b0000_1101, 4, 1'b0, 1'b0, 1'b0, ds);
      n_checks++;
      if (cfg_err !== 1'b0) $display("FAIL novl_cfg_err got=%b want=0", cfg_err); else n_pass++;
      run_stream("novl", 16'b110_1101, 7);
      run_stream("novl2", 16'b1_1101, 5);
   endtask

   task automatic test_valid_gaps();
      bit v, d, exp;
      bit [6:0] vs, ds;
      vs = 7'b1100011;
      ds = 7'b1110101;
      for (int i = 6; i >= 0; i--) begin
         v = vs[i]; d = ds[i];
         set_in(v, d, 1'b0);
         exp = v && m_match(d);
         n_checks++;
         if (dout !== exp) $display("FAIL gap_dout step=%0d got=%b want=%b", 7 - i, dout, exp);
         else n_pass++;
         clock_beat(v, d, 1'b0);
      end
   endtask

   task automatic test_cfg_err();
      bit ds;
      do_load(8'hFF, 0, 1'b1, 1'b0, 1'b0, ds);
      n_checks++;
      if (cfg_err !== 1'b1) $display("FAIL err_len0 got=%b want=1", cfg_err); else n_pass++;
      set_in(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (cfg_err !== 1'b0) $display("FAIL err_len0_pulse got=%b want=0", cfg_err); else n_pass++;
      do_load(8'hFF, PAT_MAX + 1, 1'b1, 1'b0, 1'b0, ds);
      n_checks++;
      if (cfg_err !== 1'b1) $display("FAIL err_len9 got=%b want=1", cfg_err); else n_pass++;
      run_stream("err_keep", 16'b1101, 4);
      do_load(8'b0000_0001, 1, 1'b0, 1'b0, 1'b0, ds);
      run_stream("len1", 16'b101, 3);
   endtask

   task automatic test_load_discard();
      bit ds;
      // Accepted load with a valid beat that would otherwise complete a 1-bit match.
      do_load(8'b0000_0110, 3, 1'b1, 1'b1, 1'b1, ds);
      n_checks++;
      if (ds !== 1'b0) $display("FAIL discard_dout got=%b want=0", ds); else n_pass++;
      run_stream("discard", 16'b0110_110, 7);
   endtask

   task automatic test_reset_mid();
      bit ds;
      do_load(8'b0000_1101, 4, 1'b1, 1'b0, 1'b0, ds);
      run_stream("pre_rst", 16'b110, 3);
      @(negedge clk);
      reset_n = 1'b0; din_valid = 1'b1; din = 1'b1;
      m_reset();
      #1;
      n_checks++;
      if (dout !== 1'b0) $display("FAIL mid_rst_dout got=%b want=0", dout); else n_pass++;
      @(negedge clk);
      reset_n = 1'b1; din_valid = 1'b0;
      run_stream("post_rst", 16'b1101, 4);
   endtask

   task automatic test_counter();
      bit ds;
      bit exp;
      do_load(8'b0000_0001, 1, 1'b1, 1'b0, 1'b0, ds);
      set_in(1'b0, 1'b0, 1'b1);
      clock_beat(1'b0, 1'b0, 1'b1);
      run_stream("sat", 16'b11111, 5);
      n_checks++;
      if (int'(match_cnt) !== (CNT_EN ? CNT_MAX : 0))
         $display("FAIL sat_value got=%0d want=%0d", match_cnt, CNT_EN ? CNT_MAX : 0);
      else n_pass++;
      set_in(1'b1, 1'b1, 1'b1);
      exp = m_match(1'b1);
      n_checks++;
      if (dout !== exp) $display("FAIL clr_dout got=%b want=%b", dout, exp); else n_pass++;
      clock_beat(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (match_cnt !== '0) $display("FAIL clr_wins got=%0d want=0", match_cnt); else n_pass++;
   endtask

   task automatic test_random();
      bit ds, v, d, c, exp;
      int len;
      for (int r = 0; r < 40; r++) begin
         len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) * int'($urandom_range(0, 1))
                                           : int'($urandom_range(1, 5));
         do_load(8'($urandom), len, 1'($urandom), 1'b0, 1'b0, ds);
         n_checks++;
         if (cfg_err !== m_err) $display("FAIL rnd_cfg_err round=%0d got=%b want=%b", r, cfg_err, m_err);
         else n_pass++;
         for (int b = 0; b < 25; b++) begin
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom);
            c = ($urandom_range(0, 19) == 0);
            set_in(v, d, c);
            exp = v && m_match(d);
            n_checks++;
            if (dout !== exp) $display("FAIL rnd_dout round=%0d beat=%0d got=%b want=%b", r, b, dout, exp);
            else n_pass++;
            clock_beat(v, d, c);
            n_checks++;
            if (match_cnt !== CNT_W'(m_cnt))
               $display("FAIL rnd_cnt round=%0d beat=%0d got=%0d want=%0d", r, b, match_cnt, m_cnt);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_non_overlap();
      test_valid_gaps();
      test_cfg_err();
      test_load_discard();
      test_reset_mid();
      test_counter();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
